// File: rtl/ram1rw_ctrl_pkg.sv
// Shared types for the single-port RAM initiator controller.
package ram1rw_ctrl_pkg;

    typedef enum logic {INIT, RUN} ctrl_state_t;

    typedef enum logic {GRANT_WR, GRANT_RD} grant_t;

endpackage

// File: rtl/reg_ram1rw.sv
// Single-port RAM, one access per cycle; registered read data that a write also reloads.
module reg_ram1rw #(
    parameter int WIDTH    = 32,
    parameter int LG_DEPTH = 4
) (
    input  logic                clk,
    input  logic                en_i,
    input  logic                we_i,
    input  logic [LG_DEPTH-1:0] addr_i,
    input  logic [WIDTH-1:0]    wr_data_i,
    output logic [WIDTH-1:0]    rd_data_o
);

    localparam int DEPTH = 1 << LG_DEPTH;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wr_data_i;
                rd_data_q     <= wr_data_i;
            end else begin
                rd_data_q     <= mem_q[addr_i];
            end
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/ram1rw_port_ctrl.sv
// Merges write and read request streams onto one RAM port, zero-fills after reset.
// RAM1RW_CTRL_WR_PRIO_EN: writes win every conflict instead of round-robin.
module ram1rw_port_ctrl
    import ram1rw_ctrl_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int LG_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [LG_DEPTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]    wr_data,
    input  logic                rd_valid,
    output logic                rd_ready,
    input  logic [LG_DEPTH-1:0] rd_addr,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [WIDTH-1:0]    rsp_data,
    output logic                init_done
);

    ctrl_state_t         state_q, state_d;
    logic [LG_DEPTH-1:0] ptr_q, ptr_d;
    logic                rsp_valid_q, rsp_valid_d;
`ifndef RAM1RW_CTRL_WR_PRIO_EN
    grant_t              last_q, last_d;
`endif

    logic                stall;
    logic                wr_gnt, rd_gnt;
    logic                ram_en, ram_we;
    logic [LG_DEPTH-1:0] ram_addr;
    logic [WIDTH-1:0]    ram_wdata, ram_rdata;

    // Any RAM access reloads rd_data, so a held response blocks the port entirely.
    assign stall = rsp_valid_q & ~rsp_ready;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        rsp_valid_d = rsp_valid_q;
        wr_gnt      = 1'b0;
        rd_gnt      = 1'b0;
        ram_en      = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = rd_addr;
        ram_wdata   = wr_data;
`ifndef RAM1RW_CTRL_WR_PRIO_EN
        last_d      = last_q;
`endif
        unique case (state_q)
            INIT: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = ptr_q;
                ram_wdata = '0;
                ptr_d     = ptr_q + LG_DEPTH'(1);
                if (&ptr_q) state_d = RUN;
            end
            RUN: begin
                if (!stall) begin
`ifdef RAM1RW_CTRL_WR_PRIO_EN
                    wr_gnt = wr_valid;
                    rd_gnt = rd_valid & ~wr_valid;
`else
                    if (wr_valid && rd_valid) begin
                        wr_gnt = (last_q == GRANT_RD);
                        rd_gnt = (last_q == GRANT_WR);
                    end else begin
                        wr_gnt = wr_valid;
                        rd_gnt = rd_valid;
                    end
                    if (wr_gnt)      last_d = GRANT_WR;
                    else if (rd_gnt) last_d = GRANT_RD;
`endif
                end
                ram_en   = wr_gnt | rd_gnt;
                ram_we   = wr_gnt;
                ram_addr = wr_gnt ? wr_addr : rd_addr;
                if (rd_gnt)         rsp_valid_d = 1'b1;
                else if (rsp_ready) rsp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= INIT;
            ptr_q       <= '0;
            rsp_valid_q <= 1'b0;
`ifndef RAM1RW_CTRL_WR_PRIO_EN
            last_q      <= GRANT_RD;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
`ifndef RAM1RW_CTRL_WR_PRIO_EN
            last_q      <= last_d;
`endif
        end
    end

    reg_ram1rw #(
        .WIDTH    (WIDTH),
        .LG_DEPTH (LG_DEPTH)
    ) u_ram (
        .clk       (clk),
        .en_i      (ram_en),
        .we_i      (ram_we),
        .addr_i    (ram_addr),
        .wr_data_i (ram_wdata),
        .rd_data_o (ram_rdata)
    );

    assign wr_ready  = wr_gnt;
    assign rd_ready  = rd_gnt;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = ram_rdata;
    assign init_done = (state_q == RUN);

endmodule

// File: tb/tb_ram1rw_port_ctrl.sv
// Self-checking bench for ram1rw_port_ctrl: directed vector table plus randomized traffic vs. a reference model.
module tb_ram1rw_port_ctrl;

    localparam int WIDTH    = 32;
    localparam int LG_DEPTH = 4;
    localparam int DEPTH    = 1 << LG_DEPTH;
`ifdef RAM1RW_CTRL_WR_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic                clk, reset;
    logic                wr_valid, wr_ready, rd_valid, rd_ready;
    logic [LG_DEPTH-1:0] wr_addr, rd_addr;
    logic [WIDTH-1:0]    wr_data, rsp_data;
    logic                rsp_valid, rsp_ready, init_done;

    ram1rw_port_ctrl #(.WIDTH(WIDTH), .LG_DEPTH(LG_DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_addr   (rd_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .init_done (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: array contents, the pending response, and who got the last grant.
    logic [31:0] m_mem [DEPTH];
    bit          m_rv;
    logic [31:0] m_data;
    bit          m_last_wr;
    int          m_init;

    task automatic model_reset();
        m_rv      = 1'b0;
        m_last_wr = 1'b0;
        m_init    = 0;
    endtask

    // Called right after a negedge: drive, check against model, advance model, wait next negedge.
    task automatic step(input bit wv, input logic [3:0] wa, input logic [31:0] wd,
                        input bit rv, input logic [3:0] ra, input bit rr,
                        output bit o_wr, output bit o_rd, output bit o_rv,
                        output logic [31:0] o_data, output bit o_done);
        bit gw, gr;
        wr_valid = wv; wr_addr = wa; wr_data = wd;
        rd_valid = rv; rd_addr = ra; rsp_ready = rr;
        #1;
        o_wr = wr_ready; o_rd = rd_ready; o_rv = rsp_valid; o_data = rsp_data; o_done = init_done;
        gw = 1'b0; gr = 1'b0;
        if (m_init < DEPTH) begin
            check("m_init_done", 32'(init_done), 32'd0);
            m_mem[m_init] = '0;
            m_init++;
        end else begin
            check("m_init_done", 32'(init_done), 32'd1);
            if (!(m_rv && !rr)) begin
                if (wv && rv) begin
                    if (PRIO || !m_last_wr) gw = 1'b1;
                    else                    gr = 1'b1;
                end else begin
                    gw = wv;
                    gr = rv;
                end
            end
        end
        check("m_wr_ready", 32'(wr_ready), 32'(gw));
        check("m_rd_ready", 32'(rd_ready), 32'(gr));
        check("m_rsp_valid", 32'(rsp_valid), 32'(m_rv));
        if (m_rv) check("m_rsp_data", rsp_data, m_data);
        if (gw) begin
            m_mem[wa] = wd;
            m_last_wr = 1'b1;
        end
        if (gr) begin
            m_data    = m_mem[ra];
            m_last_wr = 1'b0;
            m_rv      = 1'b1;
        end else if (rr) begin
            m_rv = 1'b0;
        end
        @(negedge clk);
    endtask

    typedef struct {
        bit          wv; logic [3:0] wa; logic [31:0] wd;
        bit          rv; logic [3:0] ra; bit rr;
        bit          ewr; bit erd; bit erv; logic [31:0] ed;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input bit wv, input logic [3:0] wa, input logic [31:0] wd,
                       input bit rv, input logic [3:0] ra, input bit rr,
                       input bit ewr, input bit erd, input bit erv, input logic [31:0] ed);
        vec_t v;
        v = '{wv, wa, wd, rv, ra, rr, ewr, erd, erv, ed};
        tbl.push_back(v);
    endtask

    initial begin
        bit          o_wr, o_rd, o_rv, o_done;
        logic [31:0] o_data;
        int          zeros;

        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'hFFFF_FFFF;
        model_reset();
        reset = 1'b1;
        wr_valid = 1'b0; rd_valid = 1'b0; rsp_ready = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_data = '0;

        @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        check("rst_rd_ready", 32'(rd_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Zero-fill must take exactly DEPTH cycles even with requests pending.
        zeros = 0;
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 4'(i), 32'hBAD0_0000, 1'b1, 4'(i), 1'b1, o_wr, o_rd, o_rv, o_data, o_done);
            if (!o_done && !o_wr && !o_rd) zeros++;
        end
        check("init_cycles", 32'(zeros), 32'(DEPTH));

        add(0, 0, 0,             1, 5, 1,  0, 1, 0, 0);
        add(0, 0, 0,             0, 0, 1,  0, 0, 1, 0);
        add(1, 3, 32'hDEADBEEF,  0, 0, 1,  1, 0, 0, 0);
        add(0, 0, 0,             1, 3, 1,  0, 1, 0, 0);
        add(0, 0, 0,             0, 0, 1,  0, 0, 1, 32'hDEADBEEF);
        for (int i = 0; i < 8; i++) begin
            if (PRIO) add(1, 4'(8 + i), 32'(256 + i), 1, 3, 1,  1, 0, 0, 0);
            else      add(1, 4'(8 + i), 32'(256 + i), 1, 3, 1,
                          (i % 2) == 0, (i % 2) == 1, ((i % 2) == 0) && (i > 0), 32'hDEADBEEF);
        end
        add(0, 0, 0,             0, 0, 1,  0, 0, !PRIO, 32'hDEADBEEF);
        add(1, 7, 32'h1234,      0, 0, 1,  1, 0, 0, 0);
        add(0, 0, 0,             1, 7, 0,  0, 1, 0, 0);
        for (int i = 0; i < 5; i++)
            add(1, 9, 32'hAAAA,  0, 0, 0,  0, 0, 1, 32'h1234);
        add(1, 9, 32'hAAAA,      0, 0, 1,  1, 0, 1, 32'h1234);
        add(0, 0, 0,             0, 0, 1,  0, 0, 0, 0);
        add(1, 15, 32'hF0F0F0F0, 0, 0, 1,  1, 0, 0, 0);
        add(1, 0, 32'h0A0A0A0A,  0, 0, 1,  1, 0, 0, 0);
        add(1, 1, 32'h11111111,  0, 0, 1,  1, 0, 0, 0);
        add(0, 0, 0,             1, 15, 1, 0, 1, 0, 0);
        add(0, 0, 0,             1, 0, 1,  0, 1, 1, 32'hF0F0F0F0);
        add(0, 0, 0,             1, 1, 1,  0, 1, 1, 32'h0A0A0A0A);
        add(0, 0, 0,             0, 0, 1,  0, 0, 1, 32'h11111111);
        add(0, 0, 0,             0, 0, 1,  0, 0, 0, 0);

        foreach (tbl[k]) begin
            step(tbl[k].wv, tbl[k].wa, tbl[k].wd, tbl[k].rv, tbl[k].ra, tbl[k].rr,
                 o_wr, o_rd, o_rv, o_data, o_done);
            check($sformatf("tbl%0d_init_done", k), 32'(o_done), 32'd1);
            check($sformatf("tbl%0d_wr_ready", k), 32'(o_wr), 32'(tbl[k].ewr));
            check($sformatf("tbl%0d_rd_ready", k), 32'(o_rd), 32'(tbl[k].erd));
            check($sformatf("tbl%0d_rsp_valid", k), 32'(o_rv), 32'(tbl[k].erv));
            if (tbl[k].erv) check($sformatf("tbl%0d_rsp_data", k), o_data, tbl[k].ed);
        end

        // Reset while a response is outstanding, then confirm the array is re-zeroed.
        step(0, 0, 0, 1, 3, 0, o_wr, o_rd, o_rv, o_data, o_done);
        check("pre_rst_rsp_valid", 32'(rsp_valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_init_done", 32'(init_done), 32'd0);
        check("midrst_rd_ready", 32'(rd_ready), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        zeros = 0;
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 0, 0, 0, 0, 1, o_wr, o_rd, o_rv, o_data, o_done);
            if (!o_done) zeros++;
        end
        check("reinit_cycles", 32'(zeros), 32'(DEPTH));
        step(0, 0, 0, 1, 3, 1, o_wr, o_rd, o_rv, o_data, o_done);
        check("reinit_rd_ready", 32'(o_rd), 32'd1);
        step(0, 0, 0, 0, 0, 1, o_wr, o_rd, o_rv, o_data, o_done);
        check("reinit_rsp_valid", 32'(o_rv), 32'd1);
        check("reinit_rsp_data", o_data, 32'd0);

        // Random traffic, consumer back-pressure about a quarter of the time.
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 1)), 4'($urandom_range(0, DEPTH - 1)), $urandom,
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, DEPTH - 1)),
                 $urandom_range(0, 3) != 0, o_wr, o_rd, o_rv, o_data, o_done);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
